// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the front-end PC select sequencer: source select codes,
// sequencer states and the PC width used by the PC select datapath.
package fetch_ctrl_pkg;

  localparam int PC_WIDTH = 32;

  typedef enum logic [1:0] {
    SEL_SEQ     = 2'd0,
    SEL_PRED    = 2'd1,
    SEL_JAL     = 2'd2,
    SEL_RECOVER = 2'd3
  } pc_sel_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/fetch_redirect_ctrl.sv
// Front-end PC source arbiter: recovery > JAL > predictor > sequential, with
// parking of blocked recoveries and the post-recovery flush window.
// Optional perf counters are enabled with `define FETCH_REDIRECT_PERF_EN.
//
// state | meaning
// RUN   | normal fetch, all sources arbitrated
// HOLD  | recovery parked in pending register until imem can take it
// FLUSH | recovery applied, decode flushed while counter runs down
module fetch_redirect_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int WIDTH        = PC_WIDTH - 1,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic           clk,
  input  logic           resetN,
  input  logic           mispredict,
  input  logic           misdirect,
  input  logic [WIDTH:0] seqPC,
  input  logic [WIDTH:0] targetAddress,
  input  logic           isJAL,
  input  logic [WIDTH:0] validAddress,
  input  logic           predictorHit,
  input  logic [WIDTH:0] predictedPC,
  input  logic           decodeStall,
  input  logic           imemReady,
  output logic [1:0]     pcSel,
  output logic [WIDTH:0] redirectPC,
  output logic           freeze,
  output logic           redirect,
  output logic           flushFetch,
  output logic           flushDecode,
  output logic           busy
`ifdef FETCH_REDIRECT_PERF_EN
  ,
  output logic [31:0]    recoverCount,
  output logic [31:0]    jalCount,
  output logic [31:0]    predCount
`endif
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  ctrl_state_t    state, state_nxt;
  logic [WIDTH:0] pending, pending_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  pc_sel_t        sel;
  logic           bk;
  logic [WIDTH:0] bk_pc;

  assign bk    = mispredict | misdirect;
  assign bk_pc = mispredict ? seqPC : targetAddress;

  always_comb begin
    sel         = SEL_SEQ;
    redirectPC  = '0;
    freeze      = 1'b0;
    redirect    = 1'b0;
    flushFetch  = 1'b0;
    flushDecode = 1'b0;
    state_nxt   = state;
    pending_nxt = pending;
    cnt_nxt     = cnt;
    if (!resetN) begin
      freeze = 1'b1;
    end else if (bk && state != HOLD) begin
      flushFetch  = 1'b1;
      flushDecode = 1'b1;
      if (imemReady) begin
        sel        = SEL_RECOVER;
        redirectPC = bk_pc;
        state_nxt  = FLUSH;
        cnt_nxt    = CNT_LOAD;
      end else begin
        freeze      = 1'b1;
        pending_nxt = bk_pc;
        state_nxt   = HOLD;
      end
    end else begin
      case (state)
        RUN: begin
          freeze = decodeStall | ~imemReady;
          if (!freeze) begin
            if (isJAL) begin
              sel        = SEL_JAL;
              redirectPC = validAddress;
            end else if (predictorHit) begin
              sel        = SEL_PRED;
              redirectPC = predictedPC;
              redirect   = 1'b1;
            end
          end
        end
        HOLD: begin
          flushFetch  = 1'b1;
          flushDecode = 1'b1;
          freeze      = ~imemReady;
          // youngest recovery overrides the parked one, even on the issue cycle
          if (imemReady) begin
            sel         = SEL_RECOVER;
            redirectPC  = bk ? bk_pc : pending;
            pending_nxt = '0;
            state_nxt   = FLUSH;
            cnt_nxt     = CNT_LOAD;
          end else if (bk) begin
            pending_nxt = bk_pc;
          end
        end
        FLUSH: begin
          flushDecode = 1'b1;
          freeze      = ~imemReady;
          if (cnt == '0) state_nxt = RUN;
          else           cnt_nxt   = cnt - CNT_W'(1);
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  assign pcSel = sel;
  assign busy  = (state != RUN);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= RUN;
      pending <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      cnt     <= cnt_nxt;
    end
  end

`ifdef FETCH_REDIRECT_PERF_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      recoverCount <= '0;
      jalCount     <= '0;
      predCount    <= '0;
    end else if (!freeze) begin
      case (sel)
        SEL_RECOVER: recoverCount <= recoverCount + 32'd1;
        SEL_JAL:     jalCount     <= jalCount + 32'd1;
        SEL_PRED:    predCount    <= predCount + 32'd1;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl: directed plan steps followed by
// random traffic, all compared against a source-priority reference model.
module tb_fetch_redirect_ctrl;

  localparam int W  = 31;
  localparam int FC = 2;

  logic         clk = 1'b0;
  logic         resetN;
  logic         mispredict, misdirect, isJAL, predictorHit, decodeStall, imemReady;
  logic [W:0]   seqPC, targetAddress, validAddress, predictedPC;
  logic [1:0]   pcSel;
  logic [W:0]   redirectPC;
  logic         freeze, redirect, flushFetch, flushDecode, busy;
`ifdef FETCH_REDIRECT_PERF_EN
  logic [31:0]  recoverCount, jalCount, predCount;
  int           m_rec, m_jal, m_pred;
`endif

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(.WIDTH(W), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .resetN(resetN),
    .mispredict(mispredict), .misdirect(misdirect),
    .seqPC(seqPC), .targetAddress(targetAddress),
    .isJAL(isJAL), .validAddress(validAddress),
    .predictorHit(predictorHit), .predictedPC(predictedPC),
    .decodeStall(decodeStall), .imemReady(imemReady),
    .pcSel(pcSel), .redirectPC(redirectPC), .freeze(freeze),
    .redirect(redirect), .flushFetch(flushFetch), .flushDecode(flushDecode),
    .busy(busy)
`ifdef FETCH_REDIRECT_PERF_EN
    , .recoverCount(recoverCount), .jalCount(jalCount), .predCount(predCount)
`endif
  );

  int errors = 0;
  int checks = 0;

  // reference model: an outstanding (parked) recovery and cycles of flush left
  bit         m_pend;
  logic [W:0] m_pend_pc;
  int         m_flush;
  int         e_sel;
  logic [W:0] e_pc;
  bit         e_frz, e_red, e_ff, e_fd, e_busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend    = 1'b0;
    m_pend_pc = '0;
    m_flush   = 0;
`ifdef FETCH_REDIRECT_PERF_EN
    m_rec = 0; m_jal = 0; m_pred = 0;
`endif
  endtask

  task automatic model_eval();
    bit         bk;
    logic [W:0] bkpc;
    bk    = mispredict || misdirect;
    bkpc  = mispredict ? seqPC : targetAddress;
    e_sel = 0; e_pc = '0; e_frz = 0; e_red = 0; e_ff = 0; e_fd = 0;
    e_busy = m_pend || (m_flush > 0);
    if (m_pend) begin
      e_ff = 1; e_fd = 1; e_frz = !imemReady;
      if (imemReady) begin e_sel = 3; e_pc = bk ? bkpc : m_pend_pc; end
    end else if (bk) begin
      e_ff = 1; e_fd = 1;
      if (imemReady) begin e_sel = 3; e_pc = bkpc; end
      else e_frz = 1;
    end else if (m_flush > 0) begin
      e_fd = 1; e_frz = !imemReady;
    end else begin
      e_frz = decodeStall || !imemReady;
      if (!e_frz) begin
        if (isJAL) begin e_sel = 2; e_pc = validAddress; end
        else if (predictorHit) begin e_sel = 1; e_pc = predictedPC; e_red = 1; end
      end
    end
  endtask

  task automatic model_update();
    bit bk;
    bk = mispredict || misdirect;
`ifdef FETCH_REDIRECT_PERF_EN
    if (!e_frz) begin
      if (e_sel == 3) m_rec++;
      else if (e_sel == 2) m_jal++;
      else if (e_sel == 1) m_pred++;
    end
`endif
    if (e_sel == 3 && !e_frz) begin
      m_pend = 0; m_flush = FC;
    end else if (m_pend || bk) begin
      m_pend = 1;
      if (bk) m_pend_pc = mispredict ? seqPC : targetAddress;
      m_flush = 0;
    end else if (m_flush > 0) begin
      m_flush--;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
    check("pcSel",       64'(pcSel),       64'(e_sel));
    check("redirectPC",  64'(redirectPC),  64'(e_pc));
    check("freeze",      64'(freeze),      64'(e_frz));
    check("redirect",    64'(redirect),    64'(e_red));
    check("flushFetch",  64'(flushFetch),  64'(e_ff));
    check("flushDecode", 64'(flushDecode), 64'(e_fd));
    check("busy",        64'(busy),        64'(e_busy));
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    mispredict = 0; misdirect = 0; isJAL = 0; predictorHit = 0; decodeStall = 0;
    imemReady = 1; seqPC = '0; targetAddress = '0; validAddress = '0; predictedPC = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    resetN = 1'b0;
    #1;
    check("rst_pcSel",   64'(pcSel), 64'd0);
    check("rst_rpc",     64'(redirectPC), 64'd0);
    check("rst_freeze",  64'(freeze), 64'd1);
    check("rst_flushD",  64'(flushDecode), 64'd0);
    check("rst_busy",    64'(busy), 64'd0);
    model_reset();
    @(posedge clk); #1;
    resetN = 1'b1;
  endtask

  initial begin
    resetN = 1'b0;
    idle_inputs();
    model_reset();
    do_reset();

    // first cycle after release: sequential, not frozen
    sample();
    check("tp1_freeze", 64'(freeze), 64'd0);
    advance();

    // JAL outranks predictor
    predictorHit = 1; predictedPC = 'h40; isJAL = 1; validAddress = 'h80;
    sample();
    check("tp2_sel", 64'(pcSel), 64'd2);
    check("tp2_pc",  64'(redirectPC), 64'h80);
    advance();

    // both backend requests with decode stalled: mispredict wins, freeze overridden
    isJAL = 0; predictorHit = 0;
    mispredict = 1; misdirect = 1; seqPC = 'h10; targetAddress = 'h20; decodeStall = 1;
    sample();
    check("tp3_pc", 64'(redirectPC), 64'h10);
    check("tp3_freeze", 64'(freeze), 64'd0);
    advance();
    mispredict = 0; misdirect = 0;
    for (int i = 0; i < FC; i++) begin
      sample();
      check("tp3_flush_win", 64'(flushDecode), 64'd1);
      advance();
    end
    sample();
    check("tp3_flush_end", 64'(flushDecode), 64'd0);
    advance();

    // recovery blocked by imem, parked, then issued
    decodeStall = 0; misdirect = 1; targetAddress = 'h55; imemReady = 0;
    sample(); advance();
    misdirect = 0;
    for (int i = 0; i < 2; i++) begin
      sample();
      check("tp4_hold_freeze", 64'(freeze), 64'd1);
      advance();
    end
    imemReady = 1;
    sample();
    check("tp4_issue_pc", 64'(redirectPC), 64'h55);
    advance();

    // predictor ignored in flush; a new recovery restarts the window
    predictorHit = 1; predictedPC = 'h40;
    sample();
    check("tp5_pred_ignored", 64'(redirect), 64'd0);
    advance();
    predictorHit = 0; mispredict = 1; seqPC = 'h99;
    sample();
    check("tp5_restart_pc", 64'(redirectPC), 64'h99);
    advance();
    mispredict = 0;
    for (int i = 0; i < FC + 1; i++) begin sample(); advance(); end

    // reset while parked discards the pending PC
    misdirect = 1; targetAddress = 'h55; imemReady = 0;
    sample(); advance();
    misdirect = 0;
    do_reset();
    imemReady = 1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("tp6_no_stale", 64'(pcSel), 64'd0);
      advance();
    end

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(199) == 0) do_reset();
      mispredict    = ($urandom_range(9) == 0);
      misdirect     = ($urandom_range(9) == 0);
      seqPC         = $urandom;
      targetAddress = $urandom;
      isJAL         = ($urandom_range(3) == 0);
      validAddress  = $urandom;
      predictorHit  = ($urandom_range(2) == 0);
      predictedPC   = $urandom;
      decodeStall   = ($urandom_range(4) == 0);
      imemReady     = ($urandom_range(3) != 0);
      sample();
      advance();
    end

`ifdef FETCH_REDIRECT_PERF_EN
    check("perf_recover", 64'(recoverCount), 64'(m_rec));
    check("perf_jal",     64'(jalCount),     64'(m_jal));
    check("perf_pred",    64'(predCount),    64'(m_pred));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
